// File: rtl/snitch_icache_pkg.sv
// Shared definitions for the instruction-cache tag lookup stage.
// Holds the per-way tag entry layout (valid, error, tag) as offset helpers
// that scale with the tag width, a packed entry type for the default
// width, and the sequencer state encoding.
package snitch_icache_pkg;

  localparam int unsigned DefaultTagWidth = 20;

  // Entry layout per way: {valid, error, tag[TagWidth-1:0]}
  function automatic int unsigned entry_width(input int unsigned tag_width);
    return tag_width + 2;
  endfunction

  function automatic int unsigned valid_pos(input int unsigned tag_width);
    return tag_width + 1;
  endfunction

  function automatic int unsigned error_pos(input int unsigned tag_width);
    return tag_width;
  endfunction

  typedef struct packed {
    logic                       valid;
    logic                       error;
    logic [DefaultTagWidth-1:0] tag;
  } tag_entry_t;

  typedef enum logic {
    StFlush = 1'b0,
    StRun   = 1'b1
  } state_e;

endpackage

// File: rtl/snitch_icache_tag_lookup_if.sv
// Bundle of the lookup, result, refill-write and tag-SRAM signals of the
// tag lookup stage. Signal names carry the direction seen from the stage
// itself (_i into the stage, _o out of it).
//   slave  : the tag lookup stage
//   master : the surrounding cache (front-end, refill unit, SRAM wrapper)
interface snitch_icache_tag_lookup_if #(
  parameter int unsigned WayCount  = 4,
  parameter int unsigned TagWidth  = 20,
  parameter int unsigned LineAlign = 7,
  parameter int unsigned IdWidth   = 4
);
  localparam int unsigned WayIdxW = (WayCount > 1) ? $clog2(WayCount) : 1;
  localparam int unsigned DataW   = WayCount * (TagWidth + 2);

  // lookup request
  logic                 lkp_valid_i;
  logic                 lkp_ready_o;
  logic [LineAlign-1:0] lkp_index_i;
  logic [TagWidth-1:0]  lkp_tag_i;
  logic [IdWidth-1:0]   lkp_id_i;
  // lookup result
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic                 out_hit_o;
  logic [WayCount-1:0]  out_way_o;
  logic                 out_error_o;
  logic [IdWidth-1:0]   out_id_o;
  logic [LineAlign-1:0] out_index_o;
  logic [TagWidth-1:0]  out_tag_o;
  // refill tag write
  logic                 wr_valid_i;
  logic                 wr_ready_o;
  logic [LineAlign-1:0] wr_index_i;
  logic [WayIdxW-1:0]   wr_way_i;
  logic [TagWidth-1:0]  wr_tag_i;
  logic                 wr_error_i;
  // tag SRAM port
  logic                 tag_req_o;
  logic                 tag_we_o;
  logic [LineAlign-1:0] tag_addr_o;
  logic [DataW-1:0]     tag_wdata_o;
  logic [WayCount-1:0]  tag_be_o;
  logic [DataW-1:0]     tag_rdata_i;

  modport slave (
    input  lkp_valid_i, lkp_index_i, lkp_tag_i, lkp_id_i,
    output lkp_ready_o,
    output out_valid_o, out_hit_o, out_way_o, out_error_o,
           out_id_o, out_index_o, out_tag_o,
    input  out_ready_i,
    input  wr_valid_i, wr_index_i, wr_way_i, wr_tag_i, wr_error_i,
    output wr_ready_o,
    output tag_req_o, tag_we_o, tag_addr_o, tag_wdata_o, tag_be_o,
    input  tag_rdata_i
  );

  modport master (
    output lkp_valid_i, lkp_index_i, lkp_tag_i, lkp_id_i,
    input  lkp_ready_o,
    input  out_valid_o, out_hit_o, out_way_o, out_error_o,
           out_id_o, out_index_o, out_tag_o,
    output out_ready_i,
    output wr_valid_i, wr_index_i, wr_way_i, wr_tag_i, wr_error_i,
    input  wr_ready_o,
    input  tag_req_o, tag_we_o, tag_addr_o, tag_wdata_o, tag_be_o,
    output tag_rdata_i
  );

endinterface

// File: rtl/snitch_icache_tag_compare.sv
// Combinational tag compare over all ways of one SRAM word.
// Ports:
//   rdata_i : WayCount packed entries {valid, error, tag}, way w at w*(TagWidth+2)
//   tag_i   : request tag
//   hit_o   : any way hit
//   way_o   : one-hot of the lowest-index hitting way, 0 on miss
//   error_o : error bit of the selected way OR more than one way hit; 0 on miss
module snitch_icache_tag_compare
  import snitch_icache_pkg::*;
#(
  parameter int unsigned WayCount = 4,
  parameter int unsigned TagWidth = 20
) (
  input  logic [WayCount*(TagWidth+2)-1:0] rdata_i,
  input  logic [TagWidth-1:0]              tag_i,
  output logic                             hit_o,
  output logic [WayCount-1:0]              way_o,
  output logic                             error_o
);

  localparam int unsigned EntryW   = entry_width(TagWidth);
  localparam int unsigned ValidPos = valid_pos(TagWidth);
  localparam int unsigned ErrorPos = error_pos(TagWidth);

  logic [WayCount-1:0] hit_vec;
  logic [WayCount-1:0] err_vec;
  logic                sel_err;
  logic                found;
  logic                multi_hit;

  for (genvar w = 0; w < WayCount; w++) begin : g_way
    assign hit_vec[w] = rdata_i[w*EntryW + ValidPos] &&
                        (rdata_i[w*EntryW +: TagWidth] == tag_i);
    assign err_vec[w] = rdata_i[w*EntryW + ErrorPos];
  end

  always_comb begin
    way_o   = '0;
    sel_err = 1'b0;
    found   = 1'b0;
    for (int w = 0; w < WayCount; w++) begin
      if (hit_vec[w] && !found) begin
        way_o[w] = 1'b1;
        sel_err  = err_vec[w];
        found    = 1'b1;
      end
    end
  end

  // clearing the lowest set bit leaves something only when two or more ways hit
  assign multi_hit = |(hit_vec & (hit_vec - WayCount'(1)));
  assign hit_o     = |hit_vec;
  assign error_o   = hit_o && (sel_err || multi_hit);

endmodule

// File: rtl/snitch_icache_tag_lookup.sv
// Tag lookup stage of the instruction cache. Owns the single tag-SRAM port
// and arbitrates flush/init, refill tag writes and lookups onto it
// (flush > write > lookup). Lookup results appear one cycle after
// acceptance from a live compare on the SRAM read data; if the result is
// not taken in that cycle it is captured so later SRAM traffic (writes,
// flush) cannot disturb it.
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset
//   flush_i        : single-cycle request to invalidate every line
//   flush_busy_o   : high while the invalidation sweep runs
//   bus (slave)    : lookup / result / refill write / tag SRAM signals
module snitch_icache_tag_lookup
  import snitch_icache_pkg::*;
#(
  parameter int unsigned WayCount  = 4,
  parameter int unsigned TagWidth  = 20,
  parameter int unsigned LineCount = 128,
  parameter int unsigned LineAlign = $clog2(LineCount),
  parameter int unsigned IdWidth   = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic flush_i,
  output logic flush_busy_o,
  snitch_icache_tag_lookup_if.slave bus
);

  localparam int unsigned DataW = WayCount * entry_width(TagWidth);
  localparam logic [LineAlign-1:0] LastLine = LineAlign'(LineCount - 1);

  state_e               state_q, state_d;
  logic [LineAlign-1:0] cnt_q, cnt_d;

  logic                 s1_valid_q, s1_valid_d;
  logic [IdWidth-1:0]   s1_id_q, s1_id_d;
  logic [LineAlign-1:0] s1_index_q, s1_index_d;
  logic [TagWidth-1:0]  s1_tag_q, s1_tag_d;

  logic                 hold_valid_q, hold_valid_d;
  logic                 hold_hit_q, hold_hit_d;
  logic [WayCount-1:0]  hold_way_q, hold_way_d;
  logic                 hold_err_q, hold_err_d;

  logic                 cmp_hit;
  logic [WayCount-1:0]  cmp_way;
  logic                 cmp_err;

  logic                 lkp_ready;
  logic                 wr_ready;
  logic                 req, we;
  logic [LineAlign-1:0] addr;
  logic [DataW-1:0]     wdata;
  logic [WayCount-1:0]  be;
  logic                 lkp_fire;
  logic                 out_fire;

  snitch_icache_tag_compare #(
    .WayCount (WayCount),
    .TagWidth (TagWidth)
  ) i_compare (
    .rdata_i (bus.tag_rdata_i),
    .tag_i   (s1_tag_q),
    .hit_o   (cmp_hit),
    .way_o   (cmp_way),
    .error_o (cmp_err)
  );

  // Arbitration and SRAM port
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lkp_ready = 1'b0;
    wr_ready  = 1'b0;
    req       = 1'b0;
    we        = 1'b0;
    addr      = '0;
    wdata     = '0;
    be        = '0;
    unique case (state_q)
      StFlush: begin
        req  = 1'b1;
        we   = 1'b1;
        addr = cnt_q;
        be   = '1;
        if (cnt_q == LastLine) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + LineAlign'(1);
        end
      end
      StRun: begin
        if (flush_i) begin
          state_d = StFlush;
          cnt_d   = '0;
        end else begin
          wr_ready  = 1'b1;
          lkp_ready = !bus.wr_valid_i && (!s1_valid_q || bus.out_ready_i);
          if (bus.wr_valid_i) begin
            req          = 1'b1;
            we           = 1'b1;
            addr         = bus.wr_index_i;
            be[bus.wr_way_i] = 1'b1;
            // same entry on every way; the byte enable picks the target way
            wdata        = {WayCount{1'b1, bus.wr_error_i, bus.wr_tag_i}};
          end else if (bus.lkp_valid_i && lkp_ready) begin
            req  = 1'b1;
            addr = bus.lkp_index_i;
          end
        end
      end
      default: begin
        state_d = StFlush;
        cnt_d   = '0;
      end
    endcase
    if (rst_i) begin
      lkp_ready = 1'b0;
      wr_ready  = 1'b0;
      req       = 1'b0;
      we        = 1'b0;
      addr      = '0;
      wdata     = '0;
      be        = '0;
    end
  end

  assign lkp_fire = bus.lkp_valid_i && lkp_ready;
  assign out_fire = s1_valid_q && bus.out_ready_i;

  // Stage-1 and result hold
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_id_d      = s1_id_q;
    s1_index_d   = s1_index_q;
    s1_tag_d     = s1_tag_q;
    hold_valid_d = hold_valid_q;
    hold_hit_d   = hold_hit_q;
    hold_way_d   = hold_way_q;
    hold_err_d   = hold_err_q;
    if (lkp_fire) begin
      s1_valid_d   = 1'b1;
      s1_id_d      = bus.lkp_id_i;
      s1_index_d   = bus.lkp_index_i;
      s1_tag_d     = bus.lkp_tag_i;
      hold_valid_d = 1'b0;
    end else if (out_fire) begin
      s1_valid_d   = 1'b0;
      hold_valid_d = 1'b0;
    end else if (s1_valid_q && !hold_valid_q) begin
      // read data is only valid in the first result cycle; capture it
      hold_valid_d = 1'b1;
      hold_hit_d   = cmp_hit;
      hold_way_d   = cmp_way;
      hold_err_d   = cmp_err;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StFlush;
      cnt_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_id_q      <= '0;
      s1_index_q   <= '0;
      s1_tag_q     <= '0;
      hold_valid_q <= 1'b0;
      hold_hit_q   <= 1'b0;
      hold_way_q   <= '0;
      hold_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      s1_valid_q   <= s1_valid_d;
      s1_id_q      <= s1_id_d;
      s1_index_q   <= s1_index_d;
      s1_tag_q     <= s1_tag_d;
      hold_valid_q <= hold_valid_d;
      hold_hit_q   <= hold_hit_d;
      hold_way_q   <= hold_way_d;
      hold_err_q   <= hold_err_d;
    end
  end

  assign flush_busy_o    = rst_i || (state_q == StFlush);

  assign bus.lkp_ready_o = lkp_ready;
  assign bus.wr_ready_o  = wr_ready;
  assign bus.tag_req_o   = req;
  assign bus.tag_we_o    = we;
  assign bus.tag_addr_o  = addr;
  assign bus.tag_wdata_o = wdata;
  assign bus.tag_be_o    = be;

  assign bus.out_valid_o = !rst_i && s1_valid_q;
  assign bus.out_hit_o   = !rst_i && s1_valid_q && (hold_valid_q ? hold_hit_q : cmp_hit);
  assign bus.out_way_o   = (!rst_i && s1_valid_q) ? (hold_valid_q ? hold_way_q : cmp_way) : '0;
  assign bus.out_error_o = !rst_i && s1_valid_q && (hold_valid_q ? hold_err_q : cmp_err);
  assign bus.out_id_o    = rst_i ? '0 : s1_id_q;
  assign bus.out_index_o = rst_i ? '0 : s1_index_q;
  assign bus.out_tag_o   = rst_i ? '0 : s1_tag_q;

endmodule

// File: tb/tb_snitch_icache_tag_lookup.sv
module tb_snitch_icache_tag_lookup;

  localparam int WAYS  = 4;
  localparam int TAGW  = 20;
  localparam int LINES = 128;
  localparam int IDXW  = 7;
  localparam int IDW   = 4;
  localparam int EW    = TAGW + 2;
  localparam int DW    = WAYS * EW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic flush_busy;

  always #5 clk = ~clk;

  snitch_icache_tag_lookup_if #(
    .WayCount(WAYS), .TagWidth(TAGW), .LineAlign(IDXW), .IdWidth(IDW)
  ) bus ();

  snitch_icache_tag_lookup #(
    .WayCount(WAYS), .TagWidth(TAGW), .LineCount(LINES), .LineAlign(IDXW), .IdWidth(IDW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .flush_busy_o (flush_busy),
    .bus          (bus)
  );

  // Tag SRAM macro model: read data one cycle after a read, garbage after a write
  logic [DW-1:0] mem [LINES];
  logic [DW-1:0] sram_rdata = '0;
  assign bus.tag_rdata_i = sram_rdata;

  always @(posedge clk) begin
    if (bus.tag_req_o) begin
      if (bus.tag_we_o) begin
        for (int w = 0; w < WAYS; w++)
          if (bus.tag_be_o[w]) mem[bus.tag_addr_o][w*EW +: EW] <= bus.tag_wdata_o[w*EW +: EW];
        sram_rdata <= '1;
      end else begin
        sram_rdata <= mem[bus.tag_addr_o];
      end
    end
  end

  int checks = 0;
  int fails  = 0;
  int last_wait;
  logic [36:0] exp_q[$];
  logic [36:0] held_exp;

  task automatic chk(input bit ok, input string nm, input logic [87:0] act, input logic [87:0] exp);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [36:0] pk(input logic h, input logic [3:0] w, input logic e,
                                     input logic [3:0] id, input logic [6:0] ix, input logic [19:0] tg);
    return {h, w, e, id, ix, tg};
  endfunction

  function automatic logic [36:0] got_result();
    return pk(bus.out_hit_o, bus.out_way_o, bus.out_error_o, bus.out_id_o, bus.out_index_o, bus.out_tag_o);
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst && bus.out_valid_o && bus.out_ready_i) begin
      if (exp_q.size() == 0) begin
        chk(1'b0, "unexpected_result", {51'd0, got_result()}, 88'd0);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        chk(got_result() == e, "result", {51'd0, got_result()}, {51'd0, e});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_phase();
    rst = 1'b1;
    @(negedge clk);
    chk(flush_busy && !bus.out_valid_o && !bus.out_hit_o && bus.out_way_o == 0 && !bus.out_error_o &&
        bus.out_id_o == 0 && bus.out_index_o == 0 && bus.out_tag_o == 0 &&
        !bus.tag_req_o && !bus.tag_we_o && bus.tag_addr_o == 0 && bus.tag_wdata_o == 0 &&
        bus.tag_be_o == 0 && !bus.lkp_ready_o && !bus.wr_ready_o,
        "reset_outputs",
        {bus.out_valid_o, bus.tag_req_o, bus.tag_we_o, bus.lkp_ready_o, bus.wr_ready_o, flush_busy},
        88'b000001);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Entered at the start of flush cycle 0
  task automatic check_flush();
    for (int i = 0; i < LINES; i++) begin
      @(negedge clk);
      chk(bus.tag_req_o && bus.tag_we_o && bus.tag_addr_o == 7'(i) && bus.tag_wdata_o == 0 &&
          bus.tag_be_o == 4'b1111 && !bus.lkp_ready_o && !bus.wr_ready_o && flush_busy &&
          !bus.out_valid_o,
          "flush_cycle", {bus.tag_req_o, bus.tag_we_o, bus.tag_be_o, bus.tag_addr_o}, {2'b11, 4'b1111, 7'(i)});
      tick();
    end
    @(negedge clk);
    chk(bus.lkp_ready_o && !flush_busy, "flush_done_ready", {bus.lkp_ready_o, flush_busy}, 2'b10);
    tick();
  endtask

  task automatic wr(input logic [6:0] ix, input logic [1:0] way, input logic [19:0] tg, input logic er);
    logic [3:0] ebe;
    ebe = 4'b0001 << way;
    bus.wr_index_i = ix; bus.wr_way_i = way; bus.wr_tag_i = tg; bus.wr_error_i = er;
    bus.wr_valid_i = 1'b1;
    @(negedge clk);
    chk(bus.wr_ready_o && bus.tag_req_o && bus.tag_we_o && bus.tag_addr_o == ix && bus.tag_be_o == ebe &&
        bus.tag_wdata_o == {WAYS{1'b1, er, tg}},
        "wr_issue", {bus.wr_ready_o, bus.tag_we_o, bus.tag_be_o, bus.tag_addr_o}, {2'b11, ebe, ix});
    tick();
    bus.wr_valid_i = 1'b0;
  endtask

  task automatic lkp(input logic [6:0] ix, input logic [19:0] tg, input logic [3:0] id,
                     input logic h, input logic [3:0] w, input logic e, input bit push);
    bus.lkp_index_i = ix; bus.lkp_tag_i = tg; bus.lkp_id_i = id;
    bus.lkp_valid_i = 1'b1;
    last_wait = 0;
    @(negedge clk);
    while (!bus.lkp_ready_o && last_wait < 50) begin
      last_wait++;
      @(negedge clk);
    end
    if (!bus.lkp_ready_o) begin
      chk(1'b0, "lkp_accept_timeout", 88'd0, 88'd1);
    end else begin
      chk(bus.tag_req_o && !bus.tag_we_o && bus.tag_addr_o == ix, "lkp_read",
          {bus.tag_req_o, bus.tag_we_o, bus.tag_addr_o}, {2'b10, ix});
      if (push) exp_q.push_back(pk(h, w, e, id, ix, tg));
    end
    tick();
    bus.lkp_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.lkp_valid_i = 0; bus.lkp_index_i = 0; bus.lkp_tag_i = 0; bus.lkp_id_i = 0;
    bus.out_ready_i = 1'b1;
    bus.wr_valid_i = 0; bus.wr_index_i = 0; bus.wr_way_i = 0; bus.wr_tag_i = 0; bus.wr_error_i = 0;

    reset_phase();
    check_flush();

    // single hit, then latency: result one cycle after acceptance
    wr(7'd5, 2'd2, 20'h12345, 1'b0);
    lkp(7'd5, 20'h12345, 4'd1, 1'b1, 4'b0100, 1'b0, 1'b1);
    @(negedge clk);
    chk(bus.out_valid_o, "lookup_latency", {87'd0, bus.out_valid_o}, 88'd1);
    tick();

    lkp(7'd5, 20'h12346, 4'd2, 1'b0, 4'b0000, 1'b0, 1'b1);
    wr(7'd9, 2'd1, 20'h54321, 1'b0);
    wr(7'd9, 2'd3, 20'h54321, 1'b0);
    lkp(7'd9, 20'h54321, 4'd3, 1'b1, 4'b0010, 1'b1, 1'b1);
    wr(7'd20, 2'd3, 20'h11111, 1'b1);
    lkp(7'd20, 20'h11111, 4'd4, 1'b1, 4'b1000, 1'b1, 1'b1);

    // back-to-back at full throughput
    lkp(7'd5, 20'h12345, 4'd5, 1'b1, 4'b0100, 1'b0, 1'b1);
    lkp(7'd9, 20'h54321, 4'd6, 1'b1, 4'b0010, 1'b1, 1'b1);
    lkp(7'd7, 20'h00000, 4'd7, 1'b0, 4'b0000, 1'b0, 1'b1);
    tick();

    // stall: result A held for 3 cycles while a write to set 5 happens
    bus.out_ready_i = 1'b0;
    lkp(7'd5, 20'h12345, 4'd8, 1'b1, 4'b0100, 1'b0, 1'b1);
    held_exp = pk(1'b1, 4'b0100, 1'b0, 4'd8, 7'd5, 20'h12345);
    bus.wr_index_i = 7'd5; bus.wr_way_i = 2'd2; bus.wr_tag_i = 20'h0BBBB; bus.wr_error_i = 1'b0;
    bus.wr_valid_i = 1'b1;
    bus.lkp_index_i = 7'd5; bus.lkp_tag_i = 20'h0BBBB; bus.lkp_id_i = 4'd9;
    bus.lkp_valid_i = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk(bus.out_valid_o && got_result() == held_exp && !bus.lkp_ready_o, "stall_hold",
          {50'd0, bus.lkp_ready_o, got_result()}, {51'd0, held_exp});
      if (s == 0) chk(bus.wr_ready_o && bus.tag_we_o, "stall_write", {bus.wr_ready_o, bus.tag_we_o}, 2'b11);
      tick();
      bus.wr_valid_i = 1'b0;
    end
    bus.out_ready_i = 1'b1;
    lkp(7'd5, 20'h0BBBB, 4'd9, 1'b1, 4'b0100, 1'b0, 1'b1);
    lkp(7'd5, 20'h12345, 4'd10, 1'b0, 4'b0000, 1'b0, 1'b1);
    tick();

    // write and lookup in the same cycle: write wins, lookup follows
    bus.wr_index_i = 7'd12; bus.wr_way_i = 2'd0; bus.wr_tag_i = 20'h0CAFE; bus.wr_error_i = 1'b0;
    bus.wr_valid_i = 1'b1;
    bus.lkp_index_i = 7'd12; bus.lkp_tag_i = 20'h0CAFE; bus.lkp_id_i = 4'd11;
    bus.lkp_valid_i = 1'b1;
    @(negedge clk);
    chk(bus.wr_ready_o && !bus.lkp_ready_o && bus.tag_we_o && bus.tag_addr_o == 7'd12, "wr_over_lkp",
        {bus.wr_ready_o, bus.lkp_ready_o, bus.tag_we_o, bus.tag_addr_o}, {3'b101, 7'd12});
    tick();
    bus.wr_valid_i = 1'b0;
    lkp(7'd12, 20'h0CAFE, 4'd11, 1'b1, 4'b0001, 1'b0, 1'b1);
    chk(last_wait == 0, "lkp_after_write", 88'(last_wait), 88'd0);

    // flush while a result is in flight; the result completes
    lkp(7'd9, 20'h54321, 4'd12, 1'b1, 4'b0010, 1'b1, 1'b1);
    flush = 1'b1;
    bus.wr_index_i = 7'd13; bus.wr_valid_i = 1'b1;
    @(negedge clk);
    chk(!bus.lkp_ready_o && !bus.wr_ready_o && !bus.tag_req_o && !flush_busy, "flush_request_cycle",
        {bus.lkp_ready_o, bus.wr_ready_o, bus.tag_req_o, flush_busy}, 4'b0000);
    tick();
    flush = 1'b0;
    bus.wr_valid_i = 1'b0;
    n = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!flush_busy) break;
      n++;
      tick();
    end
    chk(n == LINES, "flush_length", 88'(n), 88'(LINES));
    chk(bus.lkp_ready_o, "ready_after_flush", {87'd0, bus.lkp_ready_o}, 88'd1);
    tick();
    lkp(7'd5, 20'h0BBBB, 4'd13, 1'b0, 4'b0000, 1'b0, 1'b1);
    lkp(7'd12, 20'h0CAFE, 4'd14, 1'b0, 4'b0000, 1'b0, 1'b1);
    tick();

    // stalled result survives flush traffic, then reset mid-flush drops it
    wr(7'd30, 2'd1, 20'h0F00D, 1'b0);
    bus.out_ready_i = 1'b0;
    lkp(7'd30, 20'h0F00D, 4'd15, 1'b1, 4'b0010, 1'b0, 1'b0);
    held_exp = pk(1'b1, 4'b0010, 1'b0, 4'd15, 7'd30, 20'h0F00D);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (flush_busy && bus.tag_addr_o == 7'd60) break;
      n++;
      tick();
    end
    chk(flush_busy && bus.tag_addr_o == 7'd60, "reach_count_60", {flush_busy, bus.tag_addr_o}, {1'b1, 7'd60});
    chk(bus.out_valid_o && got_result() == held_exp, "held_through_flush",
        {50'd0, bus.out_valid_o, got_result()}, {50'd1, held_exp});
    tick();
    reset_phase();
    bus.out_ready_i = 1'b1;
    check_flush();

    chk(exp_q.size() == 0, "scoreboard_drained", 88'(exp_q.size()), 88'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
